// File: rtl/mbm_rr_scheduler.sv
// Round-robin scheduler sharing one signed radix-4 Booth multiplier.
// One operation in flight: IDLE (arbitrate) -> MUL -> RESP -> IDLE.
module mbm_rr_scheduler #(
    parameter int W    = 16,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_p,
    output logic                busy,
    output logic [15:0]         ops_count
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [W-1:0]     op_x_q, op_x_d;
    logic [W-1:0]     op_y_q, op_y_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [2*W-1:0]   rsp_p_q, rsp_p_d;
    logic [15:0]      ops_count_q, ops_count_d;

    logic             found;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   cand;
    logic [2*W-1:0]   product;
    logic [2*W-1:0]   xe;
    logic [W:0]       ye;
    logic [2*W-1:0]   pp;
    logic [2*W-1:0]   acc;

    // Round-robin search starting just after the last granted lane
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Accept strobe to the granted lane, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && found) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Radix-4 Booth: digits from overlapping triples of {y, 0}, sum of shifted partials
    always_comb begin
        xe  = {{W{op_x_q[W-1]}}, op_x_q};
        ye  = {op_y_q, 1'b0};
        acc = '0;
        pp  = '0;
        for (int j = 0; j < W / 2; j++) begin
            case (ye[2*j +: 3])
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * j));
        end
        product = acc;
    end

    // Next-state and datapath updates for the three-phase operation
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        ops_count_d = ops_count_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_x_d   = req_x[int'(grant)*W +: W];
                    op_y_d   = req_y[int'(grant)*W +: W];
                    op_id_d  = grant;
                    rr_ptr_d = grant;
                    state_d  = MUL;
                end
            end
            MUL: begin
                rsp_p_d     = product;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_count_d = ops_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            ops_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            ops_count_q <= ops_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign ops_count = ops_count_q;
    assign busy      = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_mbm_rr_scheduler.sv
// Directed bench for mbm_rr_scheduler with a response scoreboard.
// Grants push expected products; handshaken responses pop and compare.
module tb_mbm_rr_scheduler;

    localparam int W    = 16;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*W-1:0]    rsp_p;
    logic              busy;
    logic [15:0]       ops_count;

    mbm_rr_scheduler #(.W(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] p;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   gt[$];
    int   vec = 0;
    int   mis = 0;
    int   cyc = 0;
    int   ops_exp = 0;

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] a;
        logic signed [31:0] b;
        a = $signed(x);
        b = $signed(y);
        return a * b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        vec++;
        mis++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            ops_exp = 0;
        end else begin
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        e.id = 2'(i);
                        e.p  = model(req_x[i*W +: W], req_y[i*W +: W]);
                        sb.push_back(e);
                        gq.push_back(i);
                        gt.push_back(cyc);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    tmo("sb_empty");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_p", 64'(rsp_p), 64'(e.p));
                    ops_exp++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int lane, input logic [15:0] x, input logic [15:0] y);
        bit got;
        got = 1'b0;
        req_x[lane*W +: W] = x;
        req_y[lane*W +: W] = y;
        req_valid[lane] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready[lane]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) tmo("issue_ready");
        tick();
        req_valid[lane] = 1'b0;
    endtask

    task automatic run_op(input int lane, input logic [15:0] x, input logic [15:0] y,
                          output logic [1:0] id, output logic [31:0] p);
        bit got;
        issue(lane, x, y);
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) tmo("rsp_valid_rise");
        id = rsp_id;
        p  = rsp_p;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (!rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) tmo("rsp_valid_fall");
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (!busy && !rsp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (!got) tmo("wait_idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  id;
        logic [31:0] p;
        logic [1:0]  hid;
        logic [31:0] hp;
        logic [15:0] ops0;
        int          lane;
        logic [15:0] rx;
        logic [15:0] ry;
        int          exp_g[6];
        bit          got;

        exp_g = '{0, 1, 2, 3, 0, 1};
        rst       = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;

        // reset state
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_p", 64'(rsp_p), 64'h0);
        chk("rst_ops_count", 64'(ops_count), 64'h0);
        req_valid = '0;
        rst = 1'b0;

        // T1: single lane, 3*5
        req_x[0 +: W] = 16'd3;
        req_y[0 +: W] = 16'd5;
        req_valid[0] = 1'b1;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        chk("t1_ready_drop", 64'(req_ready), 64'h0);
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_no_rsp_yet", 64'(rsp_valid), 64'h0);
        tick();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_id", 64'(rsp_id), 64'h0);
        chk("t1_rsp_p", 64'(rsp_p), 64'h0000000F);
        tick();
        chk("t1_rsp_done", 64'(rsp_valid), 64'h0);
        chk("t1_ops_count", 64'(ops_count), 64'h1);
        chk("t1_idle", 64'(busy), 64'h0);

        // T2: signed corners
        run_op(2, 16'hFFF9, 16'd9, id, p);
        chk("t2_neg_id", 64'(id), 64'h2);
        chk("t2_neg_p", 64'(p), 64'hFFFFFFC1);
        run_op(1, 16'h8000, 16'h8000, id, p);
        chk("t2_minmin_p", 64'(p), 64'h40000000);
        run_op(3, 16'h7FFF, 16'h8000, id, p);
        chk("t2_maxmin_p", 64'(p), 64'hC0008000);

        // T3: all lanes requesting continuously from reset
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*W +: W] = 16'(100 + i);
            req_y[i*W +: W] = 16'(-(i + 2));
        end
        req_valid = '1;
        tick();
        gq.delete();
        gt.delete();
        rst = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (gq.size() >= 6) begin
                got = 1'b1;
                break;
            end
        end
        req_valid = '0;
        if (!got) tmo("t3_grants");
        wait_idle();
        for (int k = 0; k < 6; k++) begin
            if (k < gq.size()) chk("t3_grant", 64'(gq[k]), 64'(exp_g[k]));
            if (k > 0 && k < gt.size()) chk("t3_spacing", 64'(gt[k] - gt[k-1]), 64'd3);
        end

        // T4: response stall holds outputs and blocks arbitration
        rsp_ready = 1'b0;
        ops0 = ops_count;
        issue(1, 16'h1234, 16'hFF00);
        req_x[2*W +: W] = 16'd11;
        req_y[2*W +: W] = 16'd13;
        req_valid[2] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) tmo("t4_rsp_valid");
        hid = rsp_id;
        hp  = rsp_p;
        chk("t4_hold_id_first", 64'(hid), 64'h1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t4_hold_valid", 64'(rsp_valid), 64'h1);
            chk("t4_hold_id", 64'(rsp_id), 64'(hid));
            chk("t4_hold_p", 64'(rsp_p), 64'(hp));
            chk("t4_hold_ready", 64'(req_ready), 64'h0);
            chk("t4_hold_busy", 64'(busy), 64'h1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_release", 64'(rsp_valid), 64'h0);
        chk("t4_ops_count", 64'(ops_count), 64'(ops0 + 16'd1));
        chk("t4_next_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid[2] = 1'b0;
        wait_idle();

        // T5: reset during MUL drops the operation
        issue(2, 16'd77, 16'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_ops_count", 64'(ops_count), 64'h0);
        tick();
        tick();
        tick();
        chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
        req_valid = 4'b1011;
        #1;
        chk("t5_rr_restored", 64'(req_ready), 64'h1);
        req_valid = '0;
        tick();

        // T6: back-to-back random operands vs reference model
        for (int i = 0; i < 1500; i++) begin
            lane = $urandom_range(0, NREQ - 1);
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i % 50 == 0) rx = 16'h8000;
            if (i % 70 == 0) ry = 16'h7FFF;
            run_op(lane, rx, ry, id, p);
            chk("t6_id", 64'(id), 64'(lane));
            chk("t6_p", 64'(p), 64'(model(rx, ry)));
        end
        chk("t6_ops_count", 64'(ops_count), 64'(ops_exp));
        chk("t6_sb_drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
